// File: rtl/ahb_led_pkg.sv
//==============================================================================
// Module   : ahb_led_pkg
// Desc     : Shared register indices, STATUS bit positions and AHB aliases
//            for the ahb_led_ctrl LED peripheral.
// Revision : 1.0 - initial generation-2 release
//==============================================================================
`default_nettype none

package ahb_led_pkg;

  // Word index decoded from HADDR[4:2]
  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_MASK   = 3'd1,
    REG_BLINK  = 3'd2,
    REG_PERIOD = 3'd3,
    REG_DUTY   = 3'd4,
    REG_STATUS = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_idx_e;

  // STATUS register bit positions
  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_PWM_BIT   = 1;

  // HTRANS[1] set means NONSEQ or SEQ, i.e. a real transfer
  localparam int HTRANS_ACTIVE_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/ahb_led_ctrl_if.sv
//==============================================================================
// Module   : ahb_led_ctrl_if
// Desc     : AHB-Lite slave-side bus bundle for the LED peripheral.
// Revision : 1.0 - initial generation-2 release
//==============================================================================
`default_nettype none

interface ahb_led_ctrl_if;

  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRDATA
  );

endinterface

`default_nettype wire

// File: rtl/ahb_led_ctrl_blink_timer.sv
//==============================================================================
// Module   : led_blink_timer
// Desc     : Free-running half-period counter producing the shared blink
//            phase. The phase holds for period+1 cycles; a restart pulse
//            (PERIOD register write) re-aligns the timer to the off phase.
// Revision : 1.0 - initial generation-2 release
//==============================================================================
`default_nettype none

module led_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  wire logic                HCLK,
  input  wire logic                HRESET,
  input  wire logic [PERIOD_W-1:0] i_period,
  input  wire logic                i_restart,
  output logic                     o_phase
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;

  // Count up to the programmed period, then wrap and flip the phase;
  // a restart takes priority over the wrap.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == i_period) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PERIOD_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/ahb_led_ctrl.sv
//==============================================================================
// Module   : ahb_led_ctrl
// Desc     : Zero-wait-state AHB-Lite slave driving NUM_LEDS LEDs with
//            masked data writes, per-LED blink and readable registers.
//            Optional global PWM dimming is built when LED_PWM_EN is defined.
// Revision : 1.0 - initial generation-2 release
//==============================================================================
`default_nettype none

module ahb_led_ctrl
  import ahb_led_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PERIOD_W = 24,
  parameter int PWM_W    = 8
) (
  input  wire logic        HCLK,
  input  wire logic        HRESET,
  ahb_led_ctrl_if.slave    bus,
  output logic [NUM_LEDS-1:0] LED
);

`ifdef LED_PWM_EN
  localparam logic c_pwm_present = 1'b1;
`else
  localparam logic c_pwm_present = 1'b0;
  localparam int   c_unused_pwm_w = PWM_W;
`endif

  // Address-phase capture
  logic      r_sel;
  reg_idx_e  r_idx;
  logic [1:0] r_trans;
  logic      r_write;

  // Register file
  logic [NUM_LEDS-1:0] r_data;
  logic [NUM_LEDS-1:0] r_mask;
  logic [NUM_LEDS-1:0] r_blink;
  logic [PERIOD_W-1:0] r_period;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_wr_sel;
  logic                w_commit;
  logic                w_rd_valid;
  logic                w_restart;
  logic                w_phase;
  logic [NUM_LEDS-1:0] w_on;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // Capture the address phase only while the bus is ready
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sel   <= 1'b0;
      r_idx   <= REG_DATA;
      r_trans <= 2'b00;
      r_write <= 1'b0;
    end else if (bus.HREADY) begin
      r_sel   <= bus.HSEL;
      r_idx   <= reg_idx_e'(bus.HADDR[4:2]);
      r_trans <= bus.HTRANS;
      r_write <= bus.HWRITE;
    end
  end

  assign w_wr_sel   = r_sel & r_write & r_trans[HTRANS_ACTIVE_BIT];
  // The data phase only ends on an edge where HREADY is high; gating here
  // keeps a write from committing more than once if the bus is stalled.
  assign w_commit   = w_wr_sel & bus.HREADY;
  assign w_rd_valid = r_sel & ~r_write & r_trans[HTRANS_ACTIVE_BIT];
  assign w_restart  = w_commit & (r_idx == REG_PERIOD);

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] r_duty;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_pwm_on;

  // Free-running PWM counter; never reset by DUTY writes
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  // All-ones duty means fully on, so every counter value must pass
  assign w_pwm_on = (&r_duty) | (r_pwm_cnt < r_duty);
`endif

  // Register writes; DATA is stored pre-XORed with the current MASK
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_data   <= '0;
      r_mask   <= '0;
      r_blink  <= '0;
      r_period <= '0;
`ifdef LED_PWM_EN
      r_duty   <= '1;
`endif
    end else if (w_commit) begin
      case (r_idx)
        REG_DATA:   r_data   <= bus.HWDATA[NUM_LEDS-1:0] ^ r_mask;
        REG_MASK:   r_mask   <= bus.HWDATA[NUM_LEDS-1:0];
        REG_BLINK:  r_blink  <= bus.HWDATA[NUM_LEDS-1:0];
        REG_PERIOD: r_period <= bus.HWDATA[PERIOD_W-1:0];
`ifdef LED_PWM_EN
        REG_DUTY:   r_duty   <= bus.HWDATA[PWM_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  led_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_blink_timer (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .i_period  (r_period),
    .i_restart (w_restart),
    .o_phase   (w_phase)
  );

`ifdef LED_PWM_EN
  assign w_on = r_data & (~r_blink | {NUM_LEDS{w_phase}}) & {NUM_LEDS{w_pwm_on}};
`else
  assign w_on = r_data & (~r_blink | {NUM_LEDS{w_phase}});
`endif

  // Register the LED drive so outputs are glitch-free
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_led <= '0;
    end else begin
      r_led <= w_on;
    end
  end

  assign LED = r_led;

  // Read mux driven from the captured index during the data phase
  always_comb begin
    w_rdata = '0;
    if (w_rd_valid) begin
      case (r_idx)
        REG_DATA:   w_rdata = 32'(r_data);
        REG_MASK:   w_rdata = 32'(r_mask);
        REG_BLINK:  w_rdata = 32'(r_blink);
        REG_PERIOD: w_rdata = 32'(r_period);
`ifdef LED_PWM_EN
        REG_DUTY:   w_rdata = 32'(r_duty);
`endif
        REG_STATUS: begin
          w_rdata[STATUS_PHASE_BIT] = w_phase;
          w_rdata[STATUS_PWM_BIT]   = c_pwm_present;
        end
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = 1'b1;

  // Bus bits that carry no meaning for a word-only register block
  assign w_unused = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0],
                      bus.HWDATA, r_trans[0]};

endmodule

`default_nettype wire
